// File: rtl/single_port_lutram_arbiter.sv
// Two-port round-robin front end to a clear-on-reset single-port LUT RAM.
// Latency: response one cycle after accept, carrying the pre-access entry contents.
// Backpressure: ready is granted to at most one valid port per cycle; none during the sweep or on clear.

`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module single_port_lutram_arbiter #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS,
  parameter logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   clear_in,
  output logic                                   init_done_out,
  input  logic [1:0]                             req_valid_in,
  output logic [1:0]                             req_ready_out,
  input  logic [2*WRITE_MASK_LEN-1:0]            req_write_mask_in,
  input  logic [2*SET_PTR_WIDTH_IN_BITS-1:0]     req_addr_in,
  input  logic [2*SINGLE_ENTRY_SIZE_IN_BITS-1:0] req_data_in,
  output logic [1:0]                             resp_valid_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   resp_data_out
);

  localparam int W   = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int AW  = SET_PTR_WIDTH_IN_BITS;
  localparam int ML  = WRITE_MASK_LEN;
  // One extra bit so the counter can never wrap while sweeping.
  localparam int CW  = SET_PTR_WIDTH_IN_BITS + 1;
  localparam logic [CW-1:0] LAST_SET = CW'(NUM_SET - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   init_cnt_q, init_cnt_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [1:0]      resp_vld_q, resp_vld_d;
  logic [W-1:0]    resp_dat_q, resp_dat_d;

  logic [1:0]      gnt;
  logic [ML-1:0]   ram_mask;
  logic [AW-1:0]   ram_addr;
  logic [W-1:0]    ram_wdat;
  logic [W-1:0]    ram_rdat;

  // State register: sweep counter and INIT/RUN state
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: sweep all sets then run; a clear in RUN restarts the sweep
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == LAST_SET) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      default: begin
        if (clear_in) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
    endcase
  end

  // Outputs: sweep writes in INIT, round-robin grant and RAM steering in RUN
  always_comb begin
    gnt      = '0;
    ram_mask = '0;
    ram_addr = '0;
    ram_wdat = '0;
    if (state_q == ST_INIT) begin
      ram_mask = '1;
      ram_addr = init_cnt_q[AW-1:0];
      ram_wdat = INIT_VALUE;
    end else if (!clear_in) begin
      if (req_valid_in == 2'b11) begin
        gnt = rr_ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req_valid_in;
      end
      if (gnt[1]) begin
        ram_mask = req_write_mask_in[ML +: ML];
        ram_addr = req_addr_in[AW +: AW];
        ram_wdat = req_data_in[W +: W];
      end else if (gnt[0]) begin
        ram_mask = req_write_mask_in[0 +: ML];
        ram_addr = req_addr_in[0 +: AW];
        ram_wdat = req_data_in[0 +: W];
      end
    end
  end

  assign req_ready_out = gnt;
  assign init_done_out = (state_q == ST_RUN);

  // Response and pointer next values: capture pre-write read data on accept
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    resp_vld_d = gnt;
    resp_dat_d = resp_dat_q;
    if (gnt[0]) rr_ptr_d = 1'b1;
    if (gnt[1]) rr_ptr_d = 1'b0;
    if (|gnt)   resp_dat_d = ram_rdat;
  end

  // Response and round-robin pointer registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rr_ptr_q   <= 1'b0;
      resp_vld_q <= '0;
      resp_dat_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      resp_vld_q <= resp_vld_d;
      resp_dat_q <= resp_dat_d;
    end
  end

  assign resp_valid_out = resp_vld_q;
  assign resp_data_out  = resp_dat_q;

  single_port_lutram #(
    .SINGLE_ENTRY_SIZE_IN_BITS (W),
    .NUM_SET                   (NUM_SET),
    .SET_PTR_WIDTH_IN_BITS     (AW),
    .WRITE_MASK_LEN            (ML)
  ) u_ram (
    .clk_in        (clk_in),
    .write_mask_in (ram_mask),
    .addr_in       (ram_addr),
    .data_in       (ram_wdat),
    .data_out      (ram_rdat)
  );

endmodule

// Single-port LUT RAM with byte-lane write enables.
// Latency: read is asynchronous, write lands at the clock edge.
// Backpressure: none; one access per cycle.
module single_port_lutram #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS
) (
  input  logic                                 clk_in,
  input  logic [WRITE_MASK_LEN-1:0]            write_mask_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] data_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] data_out
);

  localparam int BL = `BYTE_LEN_IN_BITS;

  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_q [NUM_SET];

  // Byte-lane masked write; storage is not reset, the owner sweeps it instead
  always_ff @(posedge clk_in) begin
    for (int b = 0; b < WRITE_MASK_LEN; b++) begin
      if (write_mask_in[b]) begin
        mem_q[addr_in][b*BL +: BL] <= data_in[b*BL +: BL];
      end
    end
  end

  assign data_out = mem_q[addr_in];

endmodule

// File: tb/tb_single_port_lutram_arbiter.sv
// Self-checking bench for single_port_lutram_arbiter: directed cases plus randomized traffic.
// Latency: expects responses one cycle after each accept.
// Backpressure: requesters hold their request until granted.
module tb_single_port_lutram_arbiter;

  localparam int W  = 64;
  localparam int N  = 64;
  localparam int AW = 6;
  localparam int ML = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [1:0]    v;
  logic [ML-1:0] wm [2];
  logic [AW-1:0] ad [2];
  logic [W-1:0]  wd [2];

  logic          init_done_out;
  logic [1:0]    req_ready_out;
  logic [1:0]    resp_valid_out;
  logic [W-1:0]  resp_data_out;

  always #5 clk = ~clk;

  single_port_lutram_arbiter dut (
    .clk_in            (clk),
    .reset_in          (rst_n),
    .clear_in          (clr),
    .init_done_out     (init_done_out),
    .req_valid_in      (v),
    .req_ready_out     (req_ready_out),
    .req_write_mask_in ({wm[1], wm[0]}),
    .req_addr_in       ({ad[1], ad[0]}),
    .req_data_in       ({wd[1], wd[0]}),
    .resp_valid_out    (resp_valid_out),
    .resp_data_out     (resp_data_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: table contents, sweep progress and who was served last
  bit         m_run;
  int         m_sweep;
  int         m_last;
  logic [W-1:0] m_mem [N];
  logic [1:0] m_rvld;
  logic [W-1:0] m_rdat;
  logic [1:0] last_g;
  logic       s_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_sweep = N;
    m_last  = 1;
    m_rvld  = 2'b00;
    m_rdat  = '0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
  endtask

  // Who should be granted: only in run, never during a clear; ties go to the
  // port that was not served most recently.
  function automatic logic [1:0] model_gnt();
    if (!m_run || clr) return 2'b00;
    if (v == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic model_step(input logic [1:0] g);
    int p;
    if (!m_run) begin
      m_sweep--;
      if (m_sweep == 0) m_run = 1'b1;
      m_rvld = 2'b00;
    end else if (clr) begin
      m_run   = 1'b0;
      m_sweep = N;
      for (int i = 0; i < N; i++) m_mem[i] = '0;
      m_rvld  = 2'b00;
    end else begin
      m_rvld = g;
      if (g != 2'b00) begin
        p = g[1] ? 1 : 0;
        m_rdat = m_mem[ad[p]];
        for (int b = 0; b < ML; b++)
          if (wm[p][b]) m_mem[ad[p]][b*8 +: 8] = wd[p][b*8 +: 8];
        m_last = p;
      end
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, return at posedge+1
  task automatic cycle();
    logic [1:0] g;
    @(negedge clk);
    g = model_gnt();
    chk("ready", {62'b0, req_ready_out}, {62'b0, g});
    chk("resp_vld", {62'b0, resp_valid_out}, {62'b0, m_rvld});
    if (m_rvld != 2'b00) chk("resp_dat", resp_data_out, m_rdat);
    chk("init_done", {63'b0, init_done_out}, {63'b0, m_run});
    s_done = init_done_out;
    last_g = g;
    model_step(g);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    s_done = 1'b0;
    while (!s_done && n < 200) begin
      cycle();
      if (!s_done) n++;
    end
    chk(tag, n, N);
  endtask

  // Present one request on port p and hold it until granted (bounded)
  task automatic req(input int p, input logic [ML-1:0] m, input logic [AW-1:0] a,
                     input logic [W-1:0] d);
    bit got;
    got = 1'b0;
    v[p] = 1'b1; wm[p] = m; ad[p] = a; wd[p] = d;
    for (int i = 0; i < 8 && !got; i++) begin
      cycle();
      if (last_g[p]) got = 1'b1;
    end
    v[p] = 1'b0;
    if (!got) chk("req_timeout", {63'b0, got}, 64'd1);
  endtask

  task automatic random_traffic(input int cycles, input int clr_odds);
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && $urandom_range(1, 0) == 1) begin
          v[p]  = 1'b1;
          wm[p] = ($urandom_range(3, 0) == 0) ? 8'h00 : ML'($urandom);
          ad[p] = AW'($urandom_range(15, 0));
          wd[p] = {$urandom, $urandom};
        end
      end
      clr = ($urandom_range(clr_odds - 1, 0) == 0);
      cycle();
      for (int p = 0; p < 2; p++) if (last_g[p]) v[p] = 1'b0;
      clr = 1'b0;
    end
    v = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    v     = 2'b00;
    for (int p = 0; p < 2; p++) begin wm[p] = '0; ad[p] = '0; wd[p] = '0; end
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {62'b0, req_ready_out}, 64'd0);
    chk("rst_resp_vld", {62'b0, resp_valid_out}, 64'd0);
    chk("rst_resp_dat", resp_data_out, 64'd0);
    chk("rst_done", {63'b0, init_done_out}, 64'd0);
    #2 rst_n = 1'b1;
    wait_init("init_sweep_len");

    // Cleared table reads zero
    req(0, 8'h00, 6'd17, 64'd0);
    chk("rd17_dat", resp_data_out, 64'd0);

    // Full write then read back
    req(0, 8'hFF, 6'd5, 64'hDEADBEEF_01234567);
    chk("wr5_vld", {62'b0, resp_valid_out}, 64'd1);
    chk("wr5_old", resp_data_out, 64'd0);
    req(0, 8'h00, 6'd5, 64'd0);
    chk("rd5_vld", {62'b0, resp_valid_out}, 64'd1);
    chk("rd5_dat", resp_data_out, 64'hDEADBEEF_01234567);

    // Partial byte mask
    req(0, 8'h0F, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    req(0, 8'h00, 6'd9, 64'd0);
    chk("rd9_dat", resp_data_out, 64'h00000000_FFFFFFFF);

    // Serve port 1 so port 0 is next in line, then contend for four cycles
    req(1, 8'h00, 6'd3, 64'd0);
    chk("p1_vld", {62'b0, resp_valid_out}, 64'd2);
    wm[0] = '0; wm[1] = '0; ad[0] = 6'd20; ad[1] = 6'd21;
    v = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_gnt", {62'b0, last_g}, (i % 2) ? 64'd2 : 64'd1);
      chk("alt_resp", {62'b0, resp_valid_out}, (i % 2) ? 64'd2 : 64'd1);
      if (last_g[0]) ad[0] = ad[0] + 6'd2;
      if (last_g[1]) ad[1] = ad[1] + 6'd2;
    end
    v = 2'b00;

    // Clear while both ports request
    v = 2'b11; clr = 1'b1;
    cycle();
    chk("clr_nogrant", {62'b0, req_ready_out}, 64'd0);
    clr = 1'b0; v = 2'b00;
    wait_init("clr_sweep_len");
    req(0, 8'h00, 6'd5, 64'd0);
    chk("rd5_after_clr", resp_data_out, 64'd0);

    // Randomized traffic with occasional clears
    random_traffic(1500, 150);

    // Asynchronous reset in the middle of a burst
    wm[0] = '0; wm[1] = '0;
    v = 2'b11;
    repeat (3) begin
      cycle();
      if (last_g[0]) ad[0] = AW'($urandom_range(15, 0));
      if (last_g[1]) ad[1] = AW'($urandom_range(15, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {62'b0, req_ready_out}, 64'd0);
    chk("arst_resp_vld", {62'b0, resp_valid_out}, 64'd0);
    chk("arst_done", {63'b0, init_done_out}, 64'd0);
    model_reset();
    v = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_init("rst_sweep_len");
    req(0, 8'h00, 6'd5, 64'd0);
    chk("rd5_after_rst", resp_data_out, 64'd0);

    random_traffic(400, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/single_port_lutram_arbiter.md
Name: single_port_lutram_arbiter

Overview:
- Owns one single_port_lutram instance and shares it between two requesters (port 0, port 1) with valid/ready handshakes and round-robin arbitration.
- After reset, or on a soft-clear request, it sweeps every set to INIT_VALUE before accepting any traffic.
- Every accepted request is answered with a one-cycle registered response carrying the entry contents from before the access.
- Serves as the shared-table front end for small per-set state such as predictor or tag tables.

Parameters:
SINGLE_ENTRY_SIZE_IN_BITS, 64, entry width; multiple of `BYTE_LEN_IN_BITS
NUM_SET, 64, number of entries; power of two, at least 2
SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width
WRITE_MASK_LEN, SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS, byte-lane write mask width
INIT_VALUE, 0, value written to every entry during the clear sweep

Ports:
clk_in  input  1  clock, all state updates on the rising edge
reset_in  input  1  asynchronous, active-low reset
clear_in  input  1  soft-clear request; a one-cycle pulse restarts the sweep
init_done_out  output  1  high when the block is in RUN
req_valid_in  input  2  per-port request valid; bit p belongs to port p
req_ready_out  output  2  per-port grant
req_write_mask_in  input  2*WRITE_MASK_LEN  per-port byte mask; all zeros means read
req_addr_in  input  2*SET_PTR_WIDTH_IN_BITS  per-port set address
req_data_in  input  2*SINGLE_ENTRY_SIZE_IN_BITS  per-port write data
resp_valid_out  output  2  per-port one-cycle response pulse
resp_data_out  output  SINGLE_ENTRY_SIZE_IN_BITS  response data, shared by both ports and qualified by resp_valid_out

Behaviour:
- Reset values: init_done_out=0, req_ready_out=0, resp_valid_out=0, resp_data_out=0, init counter=0, round-robin pointer=0 (port 0 preferred), state=INIT.
- Two states, INIT and RUN.
- INIT:
  - Each cycle writes INIT_VALUE to set init_cnt with the full mask, then increments init_cnt.
  - On the cycle init_cnt==NUM_SET-1 the last write occurs; next cycle the state is RUN and init_done_out=1.
  - The sweep takes exactly NUM_SET cycles.
  - req_ready_out=0 throughout; clear_in is ignored in INIT.
- RUN, arbitration:
  - req_ready_out is combinational from req_valid_in and the pointer.
  - One valid port: that port is granted.
  - Both valid: the port selected by the pointer is granted.
  - Neither valid: no grant and no RAM write.
  - After any grant to port p, the pointer becomes !p, so two continuously valid ports alternate 0,1,0,1.
  - A request is accepted when valid&ready. At most one port is ready per cycle.
- Requester rule: once valid is asserted, the port holds valid, mask, addr and data stable until accepted. The arbiter does not check this.
- Access on acceptance:
  - The granted port's addr and mask drive the RAM.
  - A write lands at the clock edge; the read is asynchronous.
  - resp_data_out is registered from the RAM read of that address in the accept cycle, i.e. the pre-write contents.
  - resp_valid_out[p] pulses for exactly one cycle, the cycle after acceptance.
  - Latency is 1 for both reads and writes.
  - Back-to-back accepts produce back-to-back responses. A read following a write to the same address returns the new data.
- clear_in in RUN:
  - On the next edge the state goes to INIT, init_cnt=0, init_done_out=0.
  - No grant is given in the clear_in cycle; clear wins over pending requests.
  - A response already registered from the previous cycle still pulses normally.
- resp_valid_out is 0 in all cycles with no accept in the previous cycle.
- Reset mid-operation (any state) immediately zeros all outputs. A full sweep follows release; RAM contents written before reset are overwritten by the sweep.
- No counter overflow: init_cnt is SET_PTR_WIDTH_IN_BITS+1 wide or is compared before wrap.

Test Plan:
- Reset release with NUM_SET=64 -> init_done_out rises exactly 64 cycles after the first edge with reset_in high; req_ready_out=0 throughout; a read of set 17 returns 0.
- Port 0 writes 0xDEADBEEF_01234567 to set 5 with mask 0xFF, then reads set 5 -> write response data 0; read response resp_valid_out=2'b01 one cycle after accept, data 0xDEADBEEF_01234567.
- Mask 0x0F write of 0xFFFF_FFFF_FFFF_FFFF to a zeroed set 9, then read -> 0x00000000_FFFFFFFF.
- Both ports valid for 4 cycles, reading different sets -> grants 0,1,0,1; responses alternate 2'b01 / 2'b10 on consecutive cycles.
- clear_in pulse while both ports are valid -> no grant that cycle; init_done_out low for 64 cycles; afterwards previously written set 5 reads 0.
- reset_in asserted mid-burst, asynchronously between edges -> resp_valid_out, req_ready_out and init_done_out go to 0 before the next edge; normal operation resumes after a full 64-cycle sweep.
